// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath (multiplier, BCD conversion, display).
// Holds the default operand/result sizes and the conversion FSM state encoding.
package calc_pkg;

  // Binary width of the multiplier result and the BCD digit count that covers 2^32-1.
  localparam int unsigned CalcWidth  = 32;
  localparam int unsigned CalcDigits = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } calc_state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so that the
// following left shift carries correctly into the next decade.
// Ports:
//   digit_i  - 4-bit BCD digit before correction
//   digit_o  - corrected digit
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   start    - conversion request, accepted only when idle
//   bin_in   - unsigned binary value, sampled when start is accepted
//   bcd_out  - packed BCD result, digit 0 (units) in bits [3:0]; held between conversions
//   busy     - conversion in progress
//   done     - one-cycle pulse, bcd_out has just been updated
module bin_to_bcd
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH  = CalcWidth,
  parameter int unsigned DIGITS = CalcDigits
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  calc_state_e       state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic [BcdW-1:0]   scratch_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              done_q, done_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_bcd_add3 (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (scratch_adj[4*g +: 4])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin_in;
          scratch_d = '0;
          cnt_d     = CntLoad;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // {scratch, shreg} shifted left by one after the per-digit correction.
        scratch_d = {scratch_adj[BcdW-2:0], shreg_q[WIDTH-1]};
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Result only reaches bcd_out here, so partial scratch values are never visible.
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs depend on registers only
  always_comb begin
    busy    = (state_q != IDLE);
    bcd_out = bcd_q;
    done    = done_q;
  end

endmodule
